sram_dma: RTL and testbench
===========================

SRAM_DMA -- requirements
Module: sram_dma

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the SRAM word width in bits.
REQ-002 SHALL have parameter N_ENTRIES, default 128, meaning the SRAM depth in words; AW = $clog2(N_ENTRIES).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit: single-cycle job request, sampled only in IDLE.
REQ-006 SHALL have port src_i, input, AW bits: first source word address.
REQ-007 SHALL have port dst_i, input, AW bits: first destination word address.
REQ-008 SHALL have port len_i, input, AW+1 bits: word count, 0..N_ENTRIES.
REQ-009 SHALL have port busy_o, output, 1 bit: high while a job is in progress.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port mem_en_o, output, 1 bit: SRAM enable.
REQ-012 SHALL have port mem_we_o, output, 1 bit: SRAM write enable.
REQ-013 SHALL have port mem_addr_o, output, AW bits: SRAM address.
REQ-014 SHALL have port mem_wdata_o, output, DATA_WIDTH bits: SRAM write data.
REQ-015 SHALL have port mem_rdata_i, input, DATA_WIDTH bits: registered SRAM read data, valid on the cycle after a read is issued.

Function
REQ-016 SHALL implement states IDLE, RD, WR, DONE; src, dst and len are latched on the start_i edge.
REQ-017 IDLE: start_i=1 with len_i>0 -> RD; start_i=1 with len_i=0 -> DONE with no SRAM access; otherwise stay in IDLE.
REQ-018 RD: drive mem_en_o=1, mem_we_o=0, mem_addr_o=current src; next state WR.
REQ-019 WR: drive mem_en_o=1, mem_we_o=1, mem_addr_o=current dst, mem_wdata_o=mem_rdata_i; increment src and dst, decrement remaining count; next state RD if remaining count >1 after decrement bookkeeping, otherwise DONE.
REQ-020 DONE: done_o=1 for exactly one cycle, no SRAM access; next state IDLE.
REQ-021 Port outputs SHALL be combinational decodes of the state registers; in IDLE and DONE, mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL all be 0.
REQ-022 An N-word copy SHALL take exactly 2N cycles from RD entry to DONE entry; busy_o=1 in RD, WR and DONE.
REQ-023 Addresses SHALL wrap modulo N_ENTRIES; len_i=N_ENTRIES copies the whole array.
REQ-024 Words SHALL be copied in ascending address order; overlapping regions with dst>src are not protected.
REQ-025 start_i SHALL be ignored while busy_o=1.

Reset
REQ-026 rst_i=1 at any clock edge SHALL force IDLE, clear counters, and drive busy_o=0 and done_o=0; an in-flight job SHALL be abandoned with no further SRAM access.

Configuration
REQ-027 With macro SRAM_DMA_FILL_EN defined, the block SHALL add input fill_i (1 bit) and input pattern_i (DATA_WIDTH bits), both latched at start. With fill_i=1, the job SHALL skip RD and write pattern_i to dst..dst+len-1 in a FILL state, one word per cycle, taking N cycles.
REQ-028 With SRAM_DMA_FILL_EN undefined, fill_i, pattern_i and the FILL state SHALL be absent, and behaviour SHALL be copy-only.

Structure
REQ-029 The state encoding localparams SHALL be placed in the shared package/header sram_dma_pkg, together with a function that computes the length width (AW+1).
REQ-030 The block SHALL be a single module with no sub-module; the SRAM is instantiated externally by the integrator.

Verification
REQ-031 Copy: preload SRAM[0..3]=A0..A3, then start with src=0, dst=64, len=4 -> SRAM[64..67]=A0..A3, done_o pulses once, 8 cycles from RD entry to DONE entry.
REQ-032 Zero length: start with len=0 -> done_o on the next cycle, mem_en_o never asserted.
REQ-033 Wrap: start with src=126, dst=10, len=4 -> SRAM[10..13]=SRAM[126], SRAM[127], SRAM[0], SRAM[1].
REQ-034 Busy start: pulse start_i a second time during a job -> the second pulse is ignored and the first job's result is unchanged.
REQ-035 Reset mid-job: assert rst_i during the 2nd word of a len=8 job -> busy_o=0 the next cycle, only word 0 written, no later writes.
REQ-036 Fill (macro defined): fill_i=1, pattern_i=32'hDEADBEEF, dst=20, len=5 -> SRAM[20..24]=DEADBEEF, done_o after 5 write cycles.

Source files
------------

// File: rtl/sram_dma_pkg.sv
// Shared definitions for the SRAM-to-SRAM DMA engine: state encodings,
// the state enum and a helper that sizes the word-count port.
// Optional feature macro: SRAM_DMA_FILL_EN adds the FILL state.
package sram_dma_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
`ifdef SRAM_DMA_FILL_EN
  localparam logic [2:0] ST_FILL = 3'd4;
`endif

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    WR   = ST_WR,
`ifdef SRAM_DMA_FILL_EN
    FILL = ST_FILL,
`endif
    DONE = ST_DONE
  } state_e;

  // The count must hold 0..n_entries inclusive, so it is one bit wider
  // than the address.
  function automatic int len_width(input int n_entries);
    return $clog2(n_entries) + 1;
  endfunction

endpackage

// File: rtl/sram_dma.sv
// SRAM DMA engine: copies len words from src to dst inside one externally
// instantiated single-port SRAM, one read then one write per word, in
// ascending address order with modulo-N_ENTRIES wrap.
// Optional feature macro: SRAM_DMA_FILL_EN adds fill_i/pattern_i and a
// FILL state that writes a constant pattern, one word per cycle.
module sram_dma
  import sram_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_ENTRIES  = 128,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int LW = len_width(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AW-1:0]         src_i,
  input  logic [AW-1:0]         dst_i,
  input  logic [LW-1:0]         len_i,
`ifdef SRAM_DMA_FILL_EN
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e          state_q;
  state_e          state_d;
  logic [AW-1:0]   src_q;
  logic [AW-1:0]   dst_q;
  logic [LW-1:0]   cnt_q;
`ifdef SRAM_DMA_FILL_EN
  logic [DATA_WIDTH-1:0] pattern_q;
`endif

  // Address step with explicit wrap so non-power-of-two depths also wrap.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    if (a == AW'(N_ENTRIES - 1)) return '0;
    return a + AW'(1);
  endfunction

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; start_i only matters in IDLE, so a busy job ignores it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0)
            state_d = DONE;
`ifdef SRAM_DMA_FILL_EN
          else if (fill_i)
            state_d = FILL;
`endif
          else
            state_d = RD;
        end
      end
      RD:   state_d = WR;
      WR:   state_d = (cnt_q > LW'(1)) ? RD : DONE;
`ifdef SRAM_DMA_FILL_EN
      FILL: state_d = (cnt_q > LW'(1)) ? FILL : DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job registers: captured on an accepted start, stepped after each write.
  // The fill request itself is not stored; being in FILL already encodes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
`ifdef SRAM_DMA_FILL_EN
      pattern_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q     <= src_i;
            dst_q     <= dst_i;
            cnt_q     <= len_i;
`ifdef SRAM_DMA_FILL_EN
            pattern_q <= pattern_i;
`endif
          end
        end
        WR: begin
          src_q <= next_addr(src_q);
          dst_q <= next_addr(dst_q);
          cnt_q <= cnt_q - LW'(1);
        end
`ifdef SRAM_DMA_FILL_EN
        FILL: begin
          dst_q <= next_addr(dst_q);
          cnt_q <= cnt_q - LW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  // Output decode from the state registers; the bus is quiet outside RD/WR/FILL.
  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      RD: begin
        mem_en_o   = 1'b1;
        mem_addr_o = src_q;
      end
      WR: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = dst_q;
        mem_wdata_o = mem_rdata_i;
      end
`ifdef SRAM_DMA_FILL_EN
      FILL: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = dst_q;
        mem_wdata_o = pattern_q;
      end
`endif
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_dma.sv
// Self-checking bench for sram_dma: a behavioural SRAM, a shadow model of
// the array and a queue of predicted writes checked as the DUT writes.
// Optional feature macro: SRAM_DMA_FILL_EN enables the fill scenario.
module tb_sram_dma;

  localparam int DW = 32;
  localparam int N  = 128;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [6:0]    src;
  logic [6:0]    dst;
  logic [7:0]    len;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic          mem_we;
  logic [6:0]    mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef SRAM_DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] pattern;
`endif

  logic [DW-1:0] mem   [N];
  logic [DW-1:0] model [N];
  wr_t           exp_q [$];
  int            tests = 0;
  int            fails = 0;
  int            acc_count = 0;

  sram_dma #(.DATA_WIDTH(DW), .N_ENTRIES(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .src_i       (src),
    .dst_i       (dst),
    .len_i       (len),
`ifdef SRAM_DMA_FILL_EN
    .fill_i      (fill),
    .pattern_i   (pattern),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every DUT write must match the oldest predicted write.
  always @(negedge clk) begin
    if (mem_en === 1'b1) acc_count++;
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_write observed addr=%0h expected=no write", mem_addr);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check_output("write_addr", 32'(mem_addr), 32'(e.addr));
        check_output("write_data", mem_wdata, e.data);
      end
    end
  end

  // Predict the first n_pred writes of a copy (or fill) into model and queue.
  task automatic apply_stimulus(input logic [6:0] s, input logic [6:0] d,
                                input logic [7:0] l, input int n_pred,
                                input bit f, input logic [31:0] p);
    for (int i = 0; i < n_pred; i++) begin
      wr_t e;
      logic [6:0] sa, da;
      sa = s + 7'(i);
      da = d + 7'(i);
      model[da] = f ? p : model[sa];
      e.addr = da;
      e.data = model[da];
      exp_q.push_back(e);
    end
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
`ifdef SRAM_DMA_FILL_EN
    fill = f; pattern = p;
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for completion, noting first access and done cycles.
  task automatic wait_done(output int first_acc, output int done_at, output int pulses);
    first_acc = -1; done_at = -1; pulses = 0;
    for (int i = 0; i < 600; i++) begin
      if (mem_en === 1'b1 && first_acc < 0) first_acc = i;
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
      if (busy === 1'b0 && done_at >= 0) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fa, da, np, acc0;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
`ifdef SRAM_DMA_FILL_EN
    fill = 1'b0; pattern = '0;
`endif
    for (int i = 0; i < N; i++) begin
      model[i] = (i < 4) ? (32'hA000_0000 | 32'(i)) : $urandom;
      mem[i]   = model[i];
    end

    repeat (2) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_mem_en", 32'(mem_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] copy src=0 dst=64 len=4");
    apply_stimulus(7'd0, 7'd64, 8'd4, 4, 1'b0, '0);
    wait_done(fa, da, np);
    check_output("copy_first_is_read", 32'(fa), 32'd0);
    check_output("copy_latency", 32'(da - fa), 32'd8);
    check_output("copy_done_pulses", 32'(np), 32'd1);
    check_output("copy_queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 4; i++)
      check_output("copy_dst_word", mem[64 + i], 32'hA000_0000 | 32'(i));

    $display("[TB] zero length");
    acc0 = acc_count;
    apply_stimulus(7'd5, 7'd50, 8'd0, 0, 1'b0, '0);
    check_output("zero_addr_idle", 32'(mem_addr), 32'd0);
    check_output("zero_wdata_idle", mem_wdata, 32'd0);
    wait_done(fa, da, np);
    check_output("zero_done_next_cycle", 32'(da), 32'd0);
    check_output("zero_done_pulses", 32'(np), 32'd1);
    check_output("zero_no_access", 32'(acc_count - acc0), 32'd0);

    $display("[TB] wrap src=126 dst=10 len=4");
    apply_stimulus(7'd126, 7'd10, 8'd4, 4, 1'b0, '0);
    wait_done(fa, da, np);
    check_output("wrap_latency", 32'(da - fa), 32'd8);
    check_output("wrap_word0", mem[10], model[126]);
    check_output("wrap_word2", mem[12], model[0]);
    check_output("wrap_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] start while busy");
    apply_stimulus(7'd32, 7'd80, 8'd3, 3, 1'b0, '0);
    @(negedge clk);
    src = 7'd100; dst = 7'd90; len = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(fa, da, np);
    check_output("busy_done_pulses", 32'(np), 32'd1);
    repeat (6) @(negedge clk);
    check_output("busy_second_ignored", 32'(busy), 32'd0);
    check_output("busy_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset mid-job len=8");
    apply_stimulus(7'd40, 7'd96, 8'd8, 1, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    check_output("midjob_second_read", 32'({mem_en, mem_we}), 32'b10);
    rst = 1'b1;
    @(negedge clk);
    check_output("midjob_busy_cleared", 32'(busy), 32'd0);
    check_output("midjob_done_low", 32'(done), 32'd0);
    rst = 1'b0;
    acc0 = acc_count;
    repeat (20) @(negedge clk);
    check_output("midjob_no_later_access", 32'(acc_count - acc0), 32'd0);
    check_output("midjob_queue_drained", 32'(exp_q.size()), 32'd0);
    check_output("midjob_word1_untouched", mem[97], model[97]);

`ifdef SRAM_DMA_FILL_EN
    $display("[TB] fill dst=20 len=5");
    apply_stimulus(7'd0, 7'd20, 8'd5, 5, 1'b1, 32'hDEADBEEF);
    wait_done(fa, da, np);
    check_output("fill_latency", 32'(da - fa), 32'd5);
    check_output("fill_done_pulses", 32'(np), 32'd1);
    for (int i = 20; i < 25; i++)
      check_output("fill_word", mem[i], 32'hDEADBEEF);
    fill = 1'b0;
`endif

    for (int i = 0; i < N; i++)
      check_output("final_array", mem[i], model[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
